// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port integer register file with bypass, pending-write scoreboard and trigger register
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int TRIG_EN  = 1,
  parameter int TRIG_REG = 6,
  parameter int A0_REG   = 10
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NREAD-1:0][$clog2(NREGS)-1:0]    A_RD,
  output logic [NREAD-1:0][WIDTH-1:0]            RD,
  output logic [NREAD-1:0]                       RBUSY,
  input  logic [$clog2(NREGS)-1:0]               A3,
  input  logic [WIDTH-1:0]                       WD3,
  input  logic                                   WE3,
  input  logic                                   issue_en,
  input  logic [$clog2(NREGS)-1:0]               issue_rd,
  input  logic                                   trigger,
  output logic [WIDTH-1:0]                       a0,
  output logic [NREGS-1:0]                       busy_vec
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] TRIG_A = AW'(TRIG_REG);
  localparam logic [AW-1:0] A0_A   = AW'(A0_REG);

  logic [WIDTH-1:0] regs [NREGS];
  logic             s1;
  logic             s2;
  logic             wr_ok;
  logic             clr;
  logic             set;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Writes to x0 and to the hardware-owned trigger register never land.
  assign wr_ok = WE3 && (A3 != '0) && !((TRIG_EN != 0) && (A3 == TRIG_A));
  assign clr   = WE3 && (A3 != '0);
  assign set   = issue_en && (issue_rd != '0) && !((TRIG_EN != 0) && (issue_rd == TRIG_A));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= trigger;
      s2 <= s1;
      if (wr_ok) regs[A3] <= WD3;
      if (TRIG_EN != 0) regs[TRIG_A] <= {{(WIDTH-1){1'b0}}, s2};
    end
  end

  always_comb begin
    RD = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (A_RD[i] != '0) begin
        RD[i] = regs[A_RD[i]];
        if ((BYPASS != 0) && wr_ok && (A3 == A_RD[i])) RD[i] = WD3;
      end
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (clr) busy_next[A3] = 1'b0;
    if (set) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  always_comb begin
    RBUSY = '0;
    for (int i = 0; i < NREAD; i++) begin
      RBUSY[i] = busy[A_RD[i]];
      if ((BYPASS != 0) && clr && (A3 == A_RD[i]) && !(set && (issue_rd == A_RD[i])))
        RBUSY[i] = 1'b0;
    end
  end

  assign busy_vec = busy;
  assign a0       = regs[A0_A];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp (bypass and no-bypass instances)
module tb_regfile_mp;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [1:0][4:0]  a_rd;
  logic [1:0][31:0] rd, rd_nb;
  logic [1:0]       rbusy, rbusy_nb;
  logic [4:0]       a3;
  logic [31:0]      wd3;
  logic             we3;
  logic             issue_en;
  logic [4:0]       issue_rd;
  logic             trigger;
  logic [31:0]      a0, a0_nb;
  logic [31:0]      busy_vec, busy_nb;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .A_RD(a_rd), .RD(rd), .RBUSY(rbusy),
    .A3(a3), .WD3(wd3), .WE3(we3), .issue_en(issue_en), .issue_rd(issue_rd),
    .trigger(trigger), .a0(a0), .busy_vec(busy_vec)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .A_RD(a_rd), .RD(rd_nb), .RBUSY(rbusy_nb),
    .A3(a3), .WD3(wd3), .WE3(we3), .issue_en(issue_en), .issue_rd(issue_rd),
    .trigger(trigger), .a0(a0_nb), .busy_vec(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      0:       return rd[0];
      1:       return rd[1];
      2:       return rd_nb[1];
      3:       return {31'b0, rbusy[0]};
      4:       return {31'b0, rbusy_nb[0]};
      5:       return busy_vec;
      6:       return a0;
      default: return rd_nb[0];
    endcase
  endfunction

  task automatic expect_val(input int sel, input string tag, input logic [31:0] val);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%08h expected=%08h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_rd = '0; a3 = '0; wd3 = '0; we3 = 1'b0;
    issue_en = 1'b0; issue_rd = '0; trigger = 1'b0;
    a_rd[0] = 5'd5;
    expect_val(0, "reset_rd0", 32'h0);
    expect_val(3, "reset_rbusy0", 32'h0);
    expect_val(6, "reset_a0", 32'h0);
    expect_val(5, "reset_busy_vec", 32'h0);
    drain();
    tick();
    rst_n = 1'b1;

    // write x5, bypass vs no-bypass in the write cycle, then registered value
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; a_rd[0] = 5'd0; a_rd[1] = 5'd5;
    expect_val(1, "bypass_x5", 32'hDEADBEEF);
    expect_val(2, "nobypass_x5_old", 32'h0);
    drain();
    tick();
    we3 = 1'b0; a_rd[0] = 5'd5;
    expect_val(0, "read_x5", 32'hDEADBEEF);
    expect_val(7, "nb_read_x5", 32'hDEADBEEF);
    drain();

    // x0 writes dropped, issue to x0 ignored
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234; a_rd[0] = 5'd0; a_rd[1] = 5'd0;
    issue_en = 1'b1; issue_rd = 5'd0;
    expect_val(0, "x0_read_during_write", 32'h0);
    drain();
    tick();
    we3 = 1'b0; issue_en = 1'b0;
    expect_val(1, "x0_read_after_write", 32'h0);
    expect_val(5, "x0_not_busy", 32'h0);
    drain();

    // bypass on port 1 for x7
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hA5; a_rd[1] = 5'd7;
    expect_val(1, "bypass_x7", 32'hA5);
    expect_val(2, "nobypass_x7_old", 32'h0);
    drain();
    tick();
    we3 = 1'b0;
    expect_val(2, "nobypass_x7_next", 32'hA5);
    drain();

    // scoreboard set / set-wins / clear
    issue_en = 1'b1; issue_rd = 5'd3;
    tick();
    issue_en = 1'b0; a_rd[0] = 5'd3;
    expect_val(5, "busy_x3_set", 32'h8);
    expect_val(3, "rbusy_x3", 32'h1);
    drain();
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h33; issue_en = 1'b1; issue_rd = 5'd3;
    expect_val(3, "rbusy_x3_reissue", 32'h1);
    drain();
    tick();
    issue_en = 1'b0;
    expect_val(5, "busy_x3_set_wins", 32'h8);
    expect_val(3, "rbusy_x3_bypass_clear", 32'h0);
    expect_val(4, "rbusy_x3_nobypass", 32'h1);
    drain();
    tick();
    we3 = 1'b0;
    expect_val(5, "busy_x3_cleared", 32'h0);
    drain();
    issue_en = 1'b1; issue_rd = 5'd3;
    tick();
    we3 = 1'b1; a3 = 5'd3; issue_rd = 5'd9;
    tick();
    we3 = 1'b0; issue_en = 1'b0;
    expect_val(5, "busy_set_clear_diff", 32'h200);
    drain();
    issue_en = 1'b1; issue_rd = 5'd6; we3 = 1'b1; a3 = 5'd9;
    tick();
    issue_en = 1'b0; we3 = 1'b0;
    expect_val(5, "busy_trig_reg_ignored", 32'h0);
    drain();

    // trigger synchroniser: visible after the third edge
    a_rd[0] = 5'd6;
    trigger = 1'b1;
    tick();
    tick();
    expect_val(0, "trig_after_2_edges", 32'h0);
    drain();
    tick();
    expect_val(0, "trig_after_3_edges", 32'h1);
    drain();
    we3 = 1'b1; a3 = 5'd6; wd3 = 32'hFF;
    tick();
    we3 = 1'b0;
    expect_val(0, "trig_reg_write_dropped", 32'h1);
    drain();

    // a0 has no bypass, then async reset mid-cycle
    we3 = 1'b1; a3 = 5'd10; wd3 = 32'h42;
    expect_val(6, "a0_no_bypass", 32'h0);
    drain();
    tick();
    we3 = 1'b0; issue_en = 1'b1; issue_rd = 5'd12; a_rd[0] = 5'd5;
    expect_val(6, "a0_written", 32'h42);
    drain();
    tick();
    issue_en = 1'b0;
    expect_val(5, "busy_x12", 32'h1000);
    drain();
    rst_n = 1'b0;
    expect_val(6, "a0_async_reset", 32'h0);
    expect_val(5, "busy_async_reset", 32'h0);
    expect_val(0, "rd_async_reset", 32'h0);
    drain();
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
